// File: rtl/sha2_add_pkg.sv
// Shared constants for the SHA-2 modular adder tree.
//   WIDTH_SHA256 : word width of SHA-256 arithmetic (32 bits)
//   WIDTH_SHA512 : word width of SHA-512 arithmetic (64 bits)
//   N_INPUTS_T1  : operand count of the T1 sum (h + S1 + ch + K + W)
package sha2_add_pkg;

  localparam int WIDTH_SHA256 = 32;
  localparam int WIDTH_SHA512 = 64;
  localparam int N_INPUTS_T1  = 5;

endpackage

// File: rtl/mod_add_tree_if.sv
// Handshake bundle for mod_add_tree.
//   Input channel : in_valid, in_ready, in_data (packed operands), mode64, in_tag
//   Output channel: out_valid, out_ready, sum_out, out_tag
//   slave  modport: seen from the adder tree
//   master modport: seen from the producer/consumer driving the adder tree
interface mod_add_tree_if
  import sha2_add_pkg::*;
#(
  parameter int N_INPUTS = N_INPUTS_T1,
  parameter int WIDTH    = WIDTH_SHA512,
  parameter int TAG_W    = 4
);

  logic                      in_valid;
  logic                      in_ready;
  logic [N_INPUTS*WIDTH-1:0] in_data;
  logic                      mode64;
  logic [TAG_W-1:0]          in_tag;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          sum_out;
  logic [TAG_W-1:0]          out_tag;

  modport slave (
    input  in_valid, in_data, mode64, in_tag, out_ready,
    output in_ready, out_valid, sum_out, out_tag
  );

  modport master (
    output in_valid, in_data, mode64, in_tag, out_ready,
    input  in_ready, out_valid, sum_out, out_tag
  );

endinterface

// File: rtl/csa_3to2.sv
// 3:2 carry-save compressor (combinational).
//   a, b, c : three addends
//   sum     : bitwise sum (a ^ b ^ c)
//   carry   : majority vector already shifted left by one; the carry out of
//             the MSB falls off, which is exactly the mod 2^WIDTH behaviour.
// Invariant: sum + carry == a + b + c (mod 2^WIDTH).
module csa_3to2 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  logic [WIDTH-1:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | (a & c) | (b & c);
  assign carry = maj << 1;

endmodule

// File: rtl/mod_add_tree.sv
// Pipelined modular multi-operand adder.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mod_add_tree_if.slave (input and output handshake channels)
//
// Pipeline: S1 masked operands -> S2 carry-save sum/carry -> S3 final sum.
// Results leave 3 cycles after the input transfer when not stalled.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds valid and payload until that edge, and data
// is sampled only on a transfer. Every stage moves together on 'advance'
// (output register empty, or being drained this cycle); in_ready equals
// advance, so the pipe never compresses bubbles but never loses data
// either. sum_out/out_tag only change on advance, so they stay stable while
// a result waits for out_ready.
//
// mode64=0 masks each operand to its low WIDTH/2 bits and truncates the
// final sum to WIDTH/2 bits; carries that spill past the half boundary
// inside the carry-save tree are harmless because only low bits are kept.
module mod_add_tree
  import sha2_add_pkg::*;
#(
  parameter int N_INPUTS = N_INPUTS_T1,
  parameter int WIDTH    = WIDTH_SHA512,
  parameter int TAG_W    = 4
) (
  input logic           clk,
  input logic           rst,
  mod_add_tree_if.slave bus
);

  localparam int HALF = WIDTH / 2;
  localparam logic [WIDTH-1:0] HALF_MASK = {{(WIDTH - HALF){1'b0}}, {HALF{1'b1}}};

  logic advance;

  // S1: masked operands
  logic                           s1_valid;
  logic                           s1_mode;
  logic [TAG_W-1:0]               s1_tag;
  logic [N_INPUTS-1:0][WIDTH-1:0] s1_ops;

  // S2: carry-save pair
  logic             s2_valid;
  logic             s2_mode;
  logic [TAG_W-1:0] s2_tag;
  logic [WIDTH-1:0] s2_sum;
  logic [WIDTH-1:0] s2_carry;

  // S3: final result
  logic             s3_valid;
  logic [WIDTH-1:0] s3_sum;
  logic [TAG_W-1:0] s3_tag;

  logic [WIDTH-1:0]               in_mask;
  logic [N_INPUTS-1:0][WIDTH-1:0] in_masked;
  logic [WIDTH-1:0]               tree_sum;
  logic [WIDTH-1:0]               tree_carry;
  logic [WIDTH-1:0]               res_mask;
  logic [WIDTH-1:0]               result;

  assign advance      = ~s3_valid | bus.out_ready;
  assign bus.in_ready = advance;

  assign in_mask = bus.mode64 ? {WIDTH{1'b1}} : HALF_MASK;

  always_comb begin
    in_masked = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      in_masked[k] = bus.in_data[k*WIDTH +: WIDTH] & in_mask;
    end
  end

  // Carry-save reduction: level 0 seeds the pair with operands 0 and 1,
  // each further level folds in one more operand with a 3:2 compressor.
  // With two operands only level 0 exists and the tree is a pass-through.
  for (genvar k = 0; k < N_INPUTS - 1; k++) begin : g_lvl
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;
    if (k == 0) begin : g_seed
      assign s = s1_ops[0];
      assign c = s1_ops[1];
    end else begin : g_csa
      csa_3to2 #(.WIDTH(WIDTH)) u_csa (
        .a    (g_lvl[k-1].s),
        .b    (g_lvl[k-1].c),
        .c    (s1_ops[k+1]),
        .sum  (s),
        .carry(c)
      );
    end
  end

  assign tree_sum   = g_lvl[N_INPUTS-2].s;
  assign tree_carry = g_lvl[N_INPUTS-2].c;

  assign res_mask = s2_mode ? {WIDTH{1'b1}} : HALF_MASK;
  assign result   = (s2_sum + s2_carry) & res_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_tag   <= '0;
      s1_ops   <= '0;
      s2_valid <= 1'b0;
      s2_mode  <= 1'b0;
      s2_tag   <= '0;
      s2_sum   <= '0;
      s2_carry <= '0;
      s3_valid <= 1'b0;
      s3_sum   <= '0;
      s3_tag   <= '0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_mode <= bus.mode64;
        s1_tag  <= bus.in_tag;
        s1_ops  <= in_masked;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mode  <= s1_mode;
        s2_tag   <= s1_tag;
        s2_sum   <= tree_sum;
        s2_carry <= tree_carry;
      end
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_sum <= result;
        s3_tag <= s2_tag;
      end
    end
  end

  assign bus.out_valid = s3_valid;
  assign bus.sum_out   = s3_sum;
  assign bus.out_tag   = s3_tag;

endmodule
